rom_loader: RTL

- Byte-stream boot loader that acts as the writer on the instruction ROM's external load port (wen / w_addr_i / w_data_i / ren).
- Takes a framed byte stream from a UART RX or debug bridge, packs the bytes into little-endian 32-bit words, and writes them to consecutive ROM addresses.
- Holds the core in reset for the whole load. Checks length, checksum and byte timeout.
- Sits beside riscv_soc at the board top level.

---
 rtl/rom_loader_pkg.sv | 18 +
 rtl/rom_loader_byte_pack.sv | 48 ++++
 rtl/rom_loader.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the byte-stream ROM boot loader.
package rom_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/rom_loader_byte_pack.sv
// Little-endian 4-byte word assembler with a byte index and a registered word-complete pulse.
module rom_loader_byte_pack (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic        emit_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        last_o,
  output logic        word_valid_o
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic        valid_q, valid_d;

  // High while the byte being pushed completes the current word.
  assign last_o       = push_i && (idx_q == 2'd3);
  assign word_o       = word_q;
  assign word_valid_o = valid_q;

  always_comb begin
    idx_d   = idx_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clear_i) begin
      idx_d = 2'd0;
    end else if (push_i) begin
      word_d[{idx_q, 3'b000} +: 8] = byte_i;
      idx_d                        = idx_q + 2'd1;
      valid_d                      = emit_i && (idx_q == 2'd3);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q   <= 2'd0;
      word_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/rom_loader.sv
// Framed byte-stream boot loader: writes packed words to the instruction ROM load port
// while holding the core in reset, checking length, checksum and inter-byte timeout.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned MAX_WORDS   = 4096,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        rom_wen_o,
  output logic        rom_ren_o,
  output logic [31:0] rom_w_addr_o,
  output logic [31:0] rom_w_data_o,
  output logic        cpu_hold_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  localparam logic [31:0] MaxWords = 32'(MAX_WORDS);
  localparam logic [31:0] TmoLast  = 32'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] left_q, left_d;
  logic [31:0] tmo_q, tmo_d;
  logic [7:0]  csum_q, csum_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;

  logic        in_frame, accept, timed_out, start;
  logic        pack_last, pack_wen;
  logic [31:0] pack_word, len_word;
  logic [7:0]  csum_sum;

  assign in_frame  = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
  assign accept    = byte_valid_i && in_frame;
  assign timed_out = in_frame && !accept && (tmo_q == TmoLast);
  assign start     = load_start_i &&
                     ((state_q == StIdle) || (state_q == StDone) || (state_q == StErr));
  assign len_word  = {byte_data_i, pack_word[23:0]};
  assign csum_sum  = csum_q + byte_data_i;

  rom_loader_byte_pack u_pack (
    .clk_i        (clk),
    .rst_ni       (rst),
    .clear_i      (start || timed_out),
    .push_i       (accept && (state_q != StCsum)),
    .emit_i       (state_q == StData),
    .byte_i       (byte_data_i),
    .word_o       (pack_word),
    .last_o       (pack_last),
    .word_valid_o (pack_wen)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = pack_wen ? addr_q + 32'd4 : addr_q;
    left_d  = left_q;
    tmo_d   = (in_frame && !accept) ? tmo_q + 32'd1 : 32'd0;
    csum_d  = accept ? csum_sum : csum_q;
    done_d  = done_q;
    err_d   = err_q;
    code_d  = code_q;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (load_start_i) begin
          state_d = StLen;
          addr_d  = BASE_ADDR;
          csum_d  = 8'd0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          code_d  = ERR_NONE;
        end
      end
      StLen: begin
        if (pack_last) begin
          if (len_word == 32'd0) begin
            state_d = StCsum;
          end else if (len_word > MaxWords) begin
            state_d = StErr;
            err_d   = 1'b1;
            code_d  = ERR_LEN;
          end else begin
            state_d = StData;
            left_d  = len_word;
          end
        end
      end
      StData: begin
        // Leave on the last accepted byte; its write pulse lands in the first CSUM cycle.
        if (pack_last) begin
          left_d = left_q - 32'd1;
          if (left_q == 32'd1) state_d = StCsum;
        end
      end
      StCsum: begin
        if (accept) begin
          if (csum_sum == 8'd0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StErr;
            err_d   = 1'b1;
            code_d  = ERR_CSUM;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (timed_out) begin
      state_d = StErr;
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= 32'd0;
      left_q  <= 32'd0;
      tmo_q   <= 32'd0;
      csum_q  <= 8'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      tmo_q   <= tmo_d;
      csum_q  <= csum_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign byte_ready_o = in_frame;
  assign rom_wen_o    = pack_wen;
  assign busy_o       = in_frame || pack_wen;
  assign cpu_hold_o   = busy_o;
  assign rom_ren_o    = !busy_o;
  assign rom_w_addr_o = addr_q;
  assign rom_w_data_o = pack_word;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign err_code_o   = code_q;

endmodule
